// File: rtl/bsg_manycore_simd_pkg.sv
// Shared SIMD definitions: lane count, recoded-FP lane width and the vector
// typedef used by the SIMD register file and the store serializer.
package bsg_manycore_simd_pkg;

  localparam int unsigned simd_lanes_gp = 4;
  localparam int unsigned simd_width_gp = 33;

  typedef logic [simd_lanes_gp-1:0][simd_width_gp-1:0] simd_vec_t;

  typedef enum logic {
    e_idle,
    e_send
  } simd_ser_state_e;

endpackage

// File: rtl/simd_lane_pick.sv
// Picks the lowest-indexed set bit of a pending-lane mask and flags when
// exactly one lane remains.
module simd_lane_pick
  import bsg_manycore_simd_pkg::*;
#(
  parameter  int unsigned lanes_p   = simd_lanes_gp,
  localparam int unsigned lane_w_lp = (lanes_p > 1) ? $clog2(lanes_p) : 1
) (
  input  logic [lanes_p-1:0]   pending_i,
  output logic [lane_w_lp-1:0] idx_o,
  output logic                 v_o,
  output logic                 one_left_o
);

  // Scan from the top so the lowest set bit is the final assignment.
  always_comb begin
    idx_o = '0;
    for (int unsigned i = lanes_p; i > 0; i--) begin
      if (pending_i[i-1]) idx_o = lane_w_lp'(i - 1);
    end
  end

  assign v_o        = |pending_i;
  assign one_left_o = v_o && ((pending_i & (pending_i - lanes_p'(1))) == '0);

endmodule

// File: rtl/simd_store_serializer.sv
// Serializes a masked SIMD vector store into one lane store per cycle.
// Optional SIMD_SER_PERF_CNT_EN adds a 32-bit count of lanes handed off.
module simd_store_serializer
  import bsg_manycore_simd_pkg::*;
#(
  parameter  int unsigned width_p       = simd_width_gp,
  parameter  int unsigned lanes_p       = simd_lanes_gp,
  parameter  int unsigned addr_width_p  = 32,
  parameter  int unsigned lane_stride_p = 4,
  localparam int unsigned lane_w_lp     = (lanes_p > 1) ? $clog2(lanes_p) : 1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            v_i,
  input  logic [lanes_p-1:0][width_p-1:0] data_i,
  input  logic [lanes_p-1:0]              mask_i,
  input  logic [addr_width_p-1:0]         addr_i,
  output logic                            ready_o,
  output logic                            v_o,
  output logic [width_p-1:0]              data_o,
  output logic [addr_width_p-1:0]         addr_o,
  output logic [lane_w_lp-1:0]            lane_o,
  output logic                            last_o,
`ifdef SIMD_SER_PERF_CNT_EN
  output logic [31:0]                     lanes_sent_o,
`endif
  input  logic                            yumi_i
);

  localparam logic [addr_width_p-1:0] stride_lp = addr_width_p'(lane_stride_p);

  simd_ser_state_e                 state_r, state_n;
  logic [lanes_p-1:0]              pending_r, pending_n;
  logic [lanes_p-1:0][width_p-1:0] data_r;
  logic [addr_width_p-1:0]         base_r;
  logic                            accept;

  logic [lane_w_lp-1:0] pick_idx;
  logic                 pick_v;
  logic                 pick_one_left;

  simd_lane_pick #(
    .lanes_p(lanes_p)
  ) lane_pick (
    .pending_i (pending_r),
    .idx_o     (pick_idx),
    .v_o       (pick_v),
    .one_left_o(pick_one_left)
  );

  always_comb begin
    state_n   = state_r;
    pending_n = pending_r;
    accept    = 1'b0;
    case (state_r)
      e_idle: begin
        if (v_i) begin
          accept    = 1'b1;
          pending_n = mask_i;
          // An all-zero mask is latched and dropped without leaving idle.
          if (|mask_i) state_n = e_send;
        end
      end
      e_send: begin
        if (yumi_i && pick_v) begin
          pending_n[pick_idx] = 1'b0;
          if (pick_one_left) state_n = e_idle;
        end
      end
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= e_idle;
      pending_r <= '0;
      data_r    <= '0;
      base_r    <= '0;
    end else begin
      state_r   <= state_n;
      pending_r <= pending_n;
      if (accept) begin
        data_r <= data_i;
        base_r <= addr_i;
      end
    end
  end

  always_comb begin
    ready_o = (state_r == e_idle);
    v_o     = (state_r == e_send);
    data_o  = '0;
    addr_o  = '0;
    lane_o  = '0;
    last_o  = 1'b0;
    if (state_r == e_send) begin
      data_o = data_r[pick_idx];
      addr_o = base_r + addr_width_p'(pick_idx) * stride_lp;
      lane_o = pick_idx;
      last_o = pick_one_left;
    end
  end

`ifdef SIMD_SER_PERF_CNT_EN
  logic [31:0] lanes_sent_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) lanes_sent_r <= '0;
    else if (v_o && yumi_i) lanes_sent_r <= lanes_sent_r + 32'd1;
  end

  assign lanes_sent_o = lanes_sent_r;
`endif

endmodule

// File: tb/tb_simd_store_serializer.sv
// Scoreboard bench for simd_store_serializer; expected lane stores are queued
// when a request is driven and checked by a negedge monitor.
module tb_simd_store_serializer;
  import bsg_manycore_simd_pkg::*;

  typedef struct {
    logic [32:0] data;
    logic [31:0] addr;
    logic [1:0]  lane;
    logic        last;
  } exp_t;

  logic        clk_i;
  logic        reset_i;
  logic        v_i;
  simd_vec_t   data_i;
  logic [3:0]  mask_i;
  logic [31:0] addr_i;
  logic        ready_o;
  logic        v_o;
  logic [32:0] data_o;
  logic [31:0] addr_o;
  logic [1:0]  lane_o;
  logic        last_o;
  logic        yumi_i;
`ifdef SIMD_SER_PERF_CNT_EN
  logic [31:0] lanes_sent_o;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t mon_e;

  simd_store_serializer #(
    .width_p      (33),
    .lanes_p      (4),
    .addr_width_p (32),
    .lane_stride_p(4)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .v_i         (v_i),
    .data_i      (data_i),
    .mask_i      (mask_i),
    .addr_i      (addr_i),
    .ready_o     (ready_o),
    .v_o         (v_o),
    .data_o      (data_o),
    .addr_o      (addr_o),
    .lane_o      (lane_o),
    .last_o      (last_o),
`ifdef SIMD_SER_PERF_CNT_EN
    .lanes_sent_o(lanes_sent_o),
`endif
    .yumi_i      (yumi_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Every presented lane must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (v_o === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_lane: lane_o=%0d addr_o=%h data_o=%h, required no v_o", lane_o, addr_o, data_o);
      end else begin
        mon_e = sb[0];
        if (data_o !== mon_e.data || addr_o !== mon_e.addr || lane_o !== mon_e.lane || last_o !== mon_e.last) begin
          bad++;
          $display("FAIL lane_store: got lane=%0d data=%h addr=%h last=%b, required lane=%0d data=%h addr=%h last=%b",
                   lane_o, data_o, addr_o, last_o, mon_e.lane, mon_e.data, mon_e.addr, mon_e.last);
        end
        if (yumi_i === 1'b1 && reset_i === 1'b0) void'(sb.pop_front());
      end
    end
  end

  task automatic push_expected(input simd_vec_t d, input logic [3:0] m, input logic [31:0] a);
    exp_t e;
    logic [3:0] rest;
    for (int l = 0; l < 4; l++) begin
      if (m[l]) begin
        rest   = m >> (l + 1);
        e.data = d[l];
        e.addr = a + 32'(l * 4);
        e.lane = 2'(l);
        e.last = (rest == 4'b0000);
        sb.push_back(e);
      end
    end
  endtask

  // Called at posedge+1 with ready_o expected high; returns at the next posedge+1.
  task automatic send_req(input simd_vec_t d, input logic [3:0] m, input logic [31:0] a);
    total++;
    if (ready_o !== 1'b1) begin
      bad++;
      $display("FAIL send_ready: ready_o=%b, required 1", ready_o);
    end
    v_i    = 1'b1;
    data_i = d;
    mask_i = m;
    addr_i = a;
    push_expected(d, m, a);
    @(posedge clk_i); #1;
    v_i = 1'b0;
  endtask

  task automatic wait_idle(input bit rand_yumi);
    int n;
    n = 0;
    while (ready_o !== 1'b1 && n < 60) begin
      if (rand_yumi) yumi_i = 1'($urandom_range(0, 1));
      @(posedge clk_i); #1;
      n++;
    end
    total++;
    if (ready_o !== 1'b1) begin
      bad++;
      $display("FAIL idle_timeout: ready_o=%b after %0d cycles, required 1", ready_o, n);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drained: %0d lanes outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    v_i     = 1'b1;
    mask_i  = 4'hF;
    yumi_i  = 1'b1;
    repeat (3) begin
      @(posedge clk_i); #1;
      total++;
      if (v_o !== 1'b0 || data_o !== '0 || addr_o !== '0 || lane_o !== '0 || last_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs: v=%b data=%h addr=%h lane=%0d last=%b, required all 0", v_o, data_o, addr_o, lane_o, last_o);
      end
    end
    reset_i = 1'b0;
    v_i     = 1'b0;
    mask_i  = 4'h0;
    yumi_i  = 1'b0;
    total++;
    if (ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: ready_o=%b, required 1", ready_o);
    end
    @(posedge clk_i); #1;
    total++;
    if (v_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_accept: v_o=%b, required 0", v_o);
    end
  endtask

  task automatic test_full_mask;
    simd_vec_t d;
    d = '{33'd5, 33'd4, 33'd3, 33'd2};
    yumi_i = 1'b1;
    send_req(d, 4'b1111, 32'h100);
    total++;
    if (v_o !== 1'b1 || lane_o !== 2'd0 || ready_o !== 1'b0) begin
      bad++;
      $display("FAIL full_first: v=%b lane=%0d ready=%b, required v=1 lane=0 ready=0", v_o, lane_o, ready_o);
    end
    for (int i = 1; i < 4; i++) begin
      @(posedge clk_i); #1;
      total++;
      if (v_o !== 1'b1 || lane_o !== 2'(i) || addr_o !== 32'h100 + 32'(4 * i)) begin
        bad++;
        $display("FAIL full_seq: v=%b lane=%0d addr=%h, required v=1 lane=%0d addr=%h", v_o, lane_o, addr_o, i, 32'h100 + 32'(4 * i));
      end
    end
    total++;
    if (last_o !== 1'b1) begin
      bad++;
      $display("FAIL full_last: last_o=%b, required 1", last_o);
    end
    @(posedge clk_i); #1;
    total++;
    if (ready_o !== 1'b1 || v_o !== 1'b0 || data_o !== '0 || addr_o !== '0 || lane_o !== '0 || last_o !== 1'b0) begin
      bad++;
      $display("FAIL full_return_idle: ready=%b v=%b data=%h addr=%h lane=%0d last=%b, required ready=1 rest 0",
               ready_o, v_o, data_o, addr_o, lane_o, last_o);
    end
    wait_idle(1'b0);
  endtask

  task automatic test_sparse_mask;
    simd_vec_t d;
    d = '{33'd9, 33'd4, 33'd7, 33'd7};
    yumi_i = 1'b1;
    send_req(d, 4'b1010, 32'h200);
    total++;
    if (v_o !== 1'b1 || lane_o !== 2'd1 || data_o !== 33'd7 || addr_o !== 32'h204 || last_o !== 1'b0) begin
      bad++;
      $display("FAIL sparse_lane1: lane=%0d data=%h addr=%h last=%b, required lane=1 data=7 addr=204 last=0", lane_o, data_o, addr_o, last_o);
    end
    @(posedge clk_i); #1;
    total++;
    if (v_o !== 1'b1 || lane_o !== 2'd3 || data_o !== 33'd9 || addr_o !== 32'h20C || last_o !== 1'b1) begin
      bad++;
      $display("FAIL sparse_lane3: lane=%0d data=%h addr=%h last=%b, required lane=3 data=9 addr=20c last=1", lane_o, data_o, addr_o, last_o);
    end
    wait_idle(1'b0);
  endtask

  task automatic test_zero_mask;
    simd_vec_t d;
    d = '{33'd13, 33'd12, 33'd11, 33'd10};
    yumi_i = 1'b1;
    send_req(d, 4'b0000, 32'h300);
    total++;
    if (v_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL zero_drop: v=%b ready=%b, required v=0 ready=1", v_o, ready_o);
    end
    send_req(d, 4'b0100, 32'h300);
    total++;
    if (v_o !== 1'b1 || lane_o !== 2'd2 || addr_o !== 32'h308 || data_o !== 33'd12) begin
      bad++;
      $display("FAIL zero_next: v=%b lane=%0d addr=%h data=%h, required v=1 lane=2 addr=308 data=c", v_o, lane_o, addr_o, data_o);
    end
    wait_idle(1'b0);
  endtask

  task automatic test_backpressure;
    simd_vec_t d;
    d = '{33'h1_0000_0004, 33'h0_ABCD_0003, 33'd22, 33'h1_2345_6789};
    yumi_i = 1'b0;
    send_req(d, 4'b1111, 32'h400);
    v_i    = 1'b1;
    data_i = '{33'd1, 33'd1, 33'd1, 33'd1};
    mask_i = 4'b1111;
    addr_i = 32'h999;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin
        @(posedge clk_i); #1;
      end
      total++;
      if (v_o !== 1'b1 || lane_o !== 2'd0 || data_o !== 33'h1_2345_6789 || addr_o !== 32'h400 || ready_o !== 1'b0) begin
        bad++;
        $display("FAIL hold_lane0: cycle %0d v=%b lane=%0d data=%h addr=%h ready=%b, required lane 0 held", c, v_o, lane_o, data_o, addr_o, ready_o);
      end
    end
    v_i    = 1'b0;
    yumi_i = 1'b1;
    wait_idle(1'b0);
  endtask

  task automatic test_mid_reset;
    simd_vec_t d;
    int        seen;
    d = '{33'd44, 33'd33, 33'd22, 33'd11};
    yumi_i = 1'b1;
    send_req(d, 4'b1111, 32'h500);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    total++;
    if (lane_o !== 2'd2) begin
      bad++;
      $display("FAIL midreset_pre: lane_o=%0d, required 2", lane_o);
    end
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    sb.delete();
    total++;
    if (v_o !== 1'b0 || ready_o !== 1'b1 || lane_o !== '0 || addr_o !== '0) begin
      bad++;
      $display("FAIL midreset_idle: v=%b ready=%b lane=%0d addr=%h, required v=0 ready=1 lane=0 addr=0", v_o, ready_o, lane_o, addr_o);
    end
`ifdef SIMD_SER_PERF_CNT_EN
    total++;
    if (lanes_sent_o !== 32'd0) begin
      bad++;
      $display("FAIL midreset_count: lanes_sent_o=%0d, required 0", lanes_sent_o);
    end
`endif
    seen = 0;
    repeat (4) begin
      @(posedge clk_i); #1;
      if (v_o !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midreset_discard: v_o high on %0d cycles, required 0", seen);
    end
  endtask

  task automatic test_addr_wrap;
    simd_vec_t d;
    d = '{33'd0, 33'd0, 33'd66, 33'd55};
    yumi_i = 1'b1;
    send_req(d, 4'b0011, 32'hFFFF_FFFC);
    total++;
    if (lane_o !== 2'd0 || addr_o !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_lane0: lane=%0d addr=%h, required lane=0 addr=fffffffc", lane_o, addr_o);
    end
    @(posedge clk_i); #1;
    total++;
    if (lane_o !== 2'd1 || addr_o !== 32'h0000_0000 || last_o !== 1'b1) begin
      bad++;
      $display("FAIL wrap_lane1: lane=%0d addr=%h last=%b, required lane=1 addr=00000000 last=1", lane_o, addr_o, last_o);
    end
    wait_idle(1'b0);
`ifdef SIMD_SER_PERF_CNT_EN
    total++;
    if (lanes_sent_o !== 32'd2) begin
      bad++;
      $display("FAIL wrap_count: lanes_sent_o=%0d, required 2", lanes_sent_o);
    end
`endif
  endtask

  task automatic test_random;
    simd_vec_t d;
    for (int r = 0; r < 12; r++) begin
      for (int l = 0; l < 4; l++) d[l] = {1'($urandom_range(0, 1)), 32'($urandom)};
      yumi_i = 1'($urandom_range(0, 1));
      send_req(d, 4'($urandom_range(0, 15)), 32'($urandom));
      wait_idle(1'b1);
    end
    yumi_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    data_i  = '0;
    mask_i  = '0;
    addr_i  = '0;
    @(posedge clk_i); #1;
    test_reset;
    test_full_mask;
    test_sparse_mask;
    test_zero_mask;
    test_backpressure;
    test_mid_reset;
    test_addr_wrap;
    test_random;
    @(posedge clk_i); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simd_store_serializer.md
SIMD_STORE_SERIALIZER -- requirements
Module: simd_store_serializer

Interface
REQ-001 SHALL have parameter width_p, default 33, lane data width (recoded FP word).
REQ-002 SHALL have parameter lanes_p, default 4, number of SIMD lanes.
REQ-003 SHALL have parameter addr_width_p, default 32, byte address width.
REQ-004 SHALL have parameter lane_stride_p, default 4, byte offset between consecutive lanes.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have port v_i, input, 1, vector store request valid.
REQ-008 SHALL have port data_i, input, lanes_p x width_p, lane data; lane 0 is the scalar lane.
REQ-009 SHALL have port mask_i, input, lanes_p, lane enables.
REQ-010 SHALL have port addr_i, input, addr_width_p, base byte address of lane 0.
REQ-011 SHALL have port ready_o, output, 1, request may be accepted.
REQ-012 SHALL have port v_o, output, 1, lane store valid.
REQ-013 SHALL have port data_o, output, width_p, lane data.
REQ-014 SHALL have port addr_o, output, addr_width_p, lane byte address.
REQ-015 SHALL have port lane_o, output, log2(lanes_p), index of the lane being emitted.
REQ-016 SHALL have port last_o, output, 1, emitted lane is the final enabled lane.
REQ-017 SHALL have port yumi_i, input, 1, consumer takes the current lane.

Function
REQ-018 SHALL implement states IDLE and SEND; ready_o=1 only in IDLE; v_o=1 only in SEND.
REQ-019 On v_i&ready_o, SHALL latch data_i, mask_i, addr_i.
REQ-019a After that latch, SHALL go to SEND if mask_i!=0; otherwise SHALL drop the request and remain IDLE.
REQ-020 In SEND, SHALL present the lowest-indexed pending lane: data_o=buf[lane], addr_o=base+lane*lane_stride_p (modulo 2^addr_width_p), lane_o=lane.
REQ-021 last_o SHALL be 1 when exactly one pending lane remains.
REQ-022 Outputs SHALL be stable while v_o&~yumi_i; yumi_i while v_o=0 SHALL be ignored.
REQ-023 On yumi_i in SEND, SHALL clear that lane's pending bit.
REQ-023a If the lane taken is the last pending lane, SHALL return to IDLE so that ready_o=1 next cycle.
REQ-024 Latency SHALL be one cycle from accept to the first v_o; with yumi_i held high a request occupies N+1 cycles, N = popcount(mask_i).
REQ-025 No request SHALL be accepted in SEND (no overlap); v_i in SEND SHALL be ignored.
REQ-026 In IDLE, data_o, addr_o, lane_o and last_o SHALL be 0.

Reset
REQ-027 reset_i SHALL force IDLE, pending mask 0, v_o=0, ready_o=1 (after reset deasserts), and SHALL clear all other outputs to 0.
REQ-028 reset_i mid-SEND SHALL discard remaining lanes with no further v_o; reset SHALL take priority over v_i and yumi_i in the same cycle.

Configuration
REQ-029 With SIMD_SER_PERF_CNT_EN defined, SHALL add output lanes_sent_o (32 bits) that increments on each v_o&yumi_i, wraps at 2^32, and clears on reset.
REQ-030 Without SIMD_SER_PERF_CNT_EN, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Shared package bsg_manycore_simd_pkg SHALL hold the lane count constant and the SIMD vector typedef (lanes x 33-bit), reused by the SIMD register file.
REQ-032 Lowest-set-bit selection and the last-lane detect SHALL be in sub-module simd_lane_pick (input: pending mask; outputs: index, valid, one_left).

Verification
REQ-033 mask=1111, data {2,3,4,5}, addr=0x100, yumi_i tied high -> lanes 0..3 on four consecutive cycles with addr 0x100/104/108/10C; last_o=1 on lane 3; ready_o returns the following cycle.
REQ-034 mask=1010, data {7,7,4,9}, addr=0x200 -> lane1 data 7 @0x204, lane3 data 9 @0x20C with last_o=1; lanes 0 and 2 never emitted.
REQ-035 mask=0000 with v_i -> no v_o; ready_o stays 1; a following request is accepted the next cycle.
REQ-036 mask=1111, yumi_i low for 3 cycles, then high -> lane 0 held stable for 3 cycles, then normal sequence; v_i asserted during SEND is ignored.
REQ-037 reset_i asserted after lane 1 of mask=1111 is taken -> v_o=0 next cycle, ready_o=1, no lanes 2 or 3 emitted; lanes_sent_o (macro on) is 0.
REQ-038 addr=0xFFFFFFFC, mask=0011 -> lane 1 addr wraps to 0x00000000; with macro on, lanes_sent_o=2 afterward.
